mem_access_ctrl: RTL and testbench

- Initiator/master side of the 32-bit word memory port (enwr / dataIn / Dir / DataOut).
- Takes byte, halfword and word load/store requests from the datapath through a req/done handshake.
- Converts each request into memory-port cycles: plain read, plain write, or read-modify-write for sub-word stores.
- Handles byte-lane selection for both little- and big-endian, plus sign/zero extension on loads.

---
 rtl/mem_access_ctrl_if.sv | 26 ++
 rtl/mem_access_ctrl.sv | 92 +++++++++
 tb/tb_mem_access_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: datapath request/response and word-memory port signals of mem_access_ctrl
interface mem_access_ctrl_if #(parameter int ADDR_W = 5);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic              big_endian;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              mem_enwr;
  logic [31:0]       mem_dataIn;
  logic [ADDR_W-1:0] mem_Dir;
  logic [31:0]       mem_DataOut;
  modport master (
    input  req, we, size, sign_ext, big_endian, addr, wdata, mem_DataOut,
    output busy, done, err, rdata, mem_enwr, mem_dataIn, mem_Dir
  );
  modport slave (
    output req, we, size, sign_ext, big_endian, addr, wdata, mem_DataOut,
    input  busy, done, err, rdata, mem_enwr, mem_dataIn, mem_Dir
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/half/word load-store master for a 32-bit word memory, RMW for sub-word stores
module mem_access_ctrl #(parameter int ADDR_W = 5) (
  input  logic              clk,
  input  logic              rst_n,
  mem_access_ctrl_if.master bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t            r_state, w_nxt;
  logic              r_we, r_sext, r_be;
  logic [1:0]        r_size, r_off;
  logic [31:0]       r_wdata;
  logic              r_busy, r_done, r_err, r_enwr;
  logic [31:0]       r_rdata, r_dataIn;
  logic [ADDR_W-1:0] r_dir;
  logic              w_accept, w_bad, w_hi;
  logic [1:0]        w_lane;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load, w_merge;

  // RESP also accepts so that back-to-back requests skip IDLE
  assign w_accept = bus.req && (r_state == IDLE || r_state == RESP);
  assign w_bad = (bus.size == 2'b11) || (bus.size == 2'b01 && bus.addr[0]) ||
                 (bus.size == 2'b10 && bus.addr[1:0] != 2'b00) || (|(bus.addr >> (ADDR_W + 2)));

  assign w_lane = r_be ? ~r_off : r_off;
  assign w_hi   = r_off[1] ^ r_be;
  assign w_byte = 8'(bus.mem_DataOut >> {w_lane, 3'b000});
  assign w_half = w_hi ? bus.mem_DataOut[31:16] : bus.mem_DataOut[15:0];
  assign w_load = r_size == 2'b00 ? {{24{r_sext & w_byte[7]}}, w_byte} :
                  r_size == 2'b01 ? {{16{r_sext & w_half[15]}}, w_half} : bus.mem_DataOut;

  always_comb begin
    w_merge = bus.mem_DataOut;
    if (r_size == 2'b00) w_merge[{w_lane, 3'b000} +: 8] = r_wdata[7:0];
    else if (w_hi) w_merge[31:16] = r_wdata[15:0];
    else w_merge[15:0] = r_wdata[15:0];
  end

  always_comb begin
    w_nxt = r_state;
    if (w_accept) w_nxt = w_bad ? RESP : (bus.we && bus.size == 2'b10) ? WR : RD;
    else if (r_state == RD) w_nxt = r_we ? WR : RESP;
    else if (r_state == WR) w_nxt = RESP;
    else if (r_state == RESP) w_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_we     <= 1'b0;
      r_sext   <= 1'b0;
      r_be     <= 1'b0;
      r_size   <= 2'b00;
      r_off    <= 2'b00;
      r_wdata  <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_enwr   <= 1'b0;
      r_rdata  <= '0;
      r_dataIn <= '0;
      r_dir    <= '0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= w_nxt == RD || w_nxt == WR;
      r_done  <= w_nxt == RESP;
      r_err   <= w_accept && w_bad;
      r_enwr  <= w_nxt == WR;
      if (w_accept) begin
        r_we     <= bus.we;
        r_size   <= bus.size;
        r_sext   <= bus.sign_ext;
        r_be     <= bus.big_endian;
        r_off    <= bus.addr[1:0];
        r_wdata  <= bus.wdata;
        r_dir    <= bus.addr[ADDR_W+1:2];
        r_dataIn <= bus.wdata;
      end
      if (r_state == RD) r_dataIn <= w_merge;
      if (r_state == RD && !r_we) r_rdata <= w_load;
    end
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.rdata      = r_rdata;
  assign bus.mem_enwr   = r_enwr;
  assign bus.mem_dataIn = r_dataIn;
  assign bus.mem_Dir    = r_dir;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed and random load/store requests checked against a byte-lane memory model
module tb_mem_access_ctrl;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  int n_wr = 0;
  logic [31:0] mem [32] = '{default: '0};
  logic [31:0] ref_mem [32] = '{default: '0};
  logic [31:0] exp_rdata = '0;

  mem_access_ctrl_if #(.ADDR_W(AW)) bus();
  mem_access_ctrl #(.ADDR_W(AW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  assign bus.mem_DataOut = mem[bus.mem_Dir];
  always @(posedge clk) begin
    if (bus.mem_enwr) begin
      mem[bus.mem_Dir] <= bus.mem_dataIn;
      n_wr++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Memory seen as 4 byte lanes per word; big-endian reverses lane numbering
  task automatic model(input logic w, input logic [1:0] sz, input logic sx, input logic be,
                       input logic [31:0] a, input logic [31:0] d, output logic e, output int lat);
    int o, idx, sh;
    logic [31:0] mask, v;
    e = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) || a >= 32'd128;
    lat = e ? 1 : (w && sz != 2'd2) ? 3 : 2;
    if (e) return;
    o = int'(a[1:0]);
    idx = int'(a[6:2]);
    sh = sz == 2'd0 ? 8 * (be ? 3 - o : o) : sz == 2'd1 ? 16 * (be ? 1 - o / 2 : o / 2) : 0;
    mask = sz == 2'd0 ? 32'hFF : sz == 2'd1 ? 32'hFFFF : 32'hFFFF_FFFF;
    if (w) ref_mem[idx] = (ref_mem[idx] & ~(mask << sh)) | ((d & mask) << sh);
    else begin
      v = (ref_mem[idx] >> sh) & mask;
      if (sx && sz != 2'd2 && v > (mask >> 1)) v = v | ~mask;
      exp_rdata = v;
    end
  endtask

  task automatic do_req(input string tag, input logic w, input logic [1:0] sz, input logic sx,
                        input logic be, input logic [31:0] a, input logic [31:0] d);
    logic e;
    int lat, got_lat, wr0;
    model(w, sz, sx, be, a, d, e, lat);
    @(negedge clk);
    bus.req = 1'b1; bus.we = w; bus.size = sz; bus.sign_ext = sx;
    bus.big_endian = be; bus.addr = a; bus.wdata = d;
    wr0 = n_wr;
    @(posedge clk);
    #1 bus.req = 1'b0;
    got_lat = 0;
    for (int c = 1; c <= 6 && got_lat == 0; c++) begin
      @(negedge clk);
      if (bus.done) got_lat = c;
      else check({tag, " busy"}, 32'(bus.busy), 32'd1);
    end
    check({tag, " latency"}, got_lat, lat);
    if (got_lat != 0) begin
      check({tag, " err"}, 32'(bus.err), 32'(e));
      check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
      check({tag, " rdata"}, bus.rdata, exp_rdata);
    end
    check({tag, " writes"}, n_wr - wr0, (w && !e) ? 1 : 0);
    if (!e) check({tag, " mem word"}, mem[a[6:2]], ref_mem[a[6:2]]);
  endtask

  initial begin
    int first, second;
    logic [31:0] exp1, exp2, a;
    logic [1:0] sz;
    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.sign_ext = 1'b0;
    bus.big_endian = 1'b0; bus.addr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst err", 32'(bus.err), 32'd0);
    check("rst enwr", 32'(bus.mem_enwr), 32'd0);
    check("rst rdata", bus.rdata, 32'd0);
    check("rst dataIn", bus.mem_dataIn, 32'd0);
    check("rst Dir", 32'(bus.mem_Dir), 32'd0);
    rst_n = 1'b1;

    do_req("wst08", 1, 2'd2, 0, 0, 32'h08, 32'hDEADBEEF);
    check("mem[2]", mem[2], 32'hDEADBEEF);
    do_req("wld08", 0, 2'd2, 0, 0, 32'h08, 32'h0);
    check("wld08 value", bus.rdata, 32'hDEADBEEF);

    do_req("wst04", 1, 2'd2, 0, 0, 32'h04, 32'h11223344);
    do_req("bst05", 1, 2'd0, 0, 0, 32'h05, 32'h000000AA);
    check("mem[1] byte", mem[1], 32'h1122AA44);
    do_req("bld05s", 0, 2'd0, 1, 0, 32'h05, 32'h0);
    check("bld05s value", bus.rdata, 32'hFFFFFFAA);
    do_req("bld05u", 0, 2'd0, 0, 0, 32'h05, 32'h0);
    check("bld05u value", bus.rdata, 32'h000000AA);

    do_req("wst04b", 1, 2'd2, 0, 0, 32'h04, 32'h11223344);
    do_req("hst04be", 1, 2'd1, 0, 1, 32'h04, 32'h0000BEEF);
    check("mem[1] half", mem[1], 32'hBEEF3344);
    do_req("hld06be", 0, 2'd1, 0, 1, 32'h06, 32'h0);
    check("hld06be value", bus.rdata, 32'h00003344);

    do_req("err half03", 0, 2'd1, 0, 0, 32'h03, 32'h0);
    do_req("err word82", 1, 2'd2, 0, 0, 32'h82, 32'h12345678);
    do_req("err size3", 0, 2'd3, 0, 0, 32'h10, 32'h0);
    check("err rdata kept", bus.rdata, 32'h00003344);

    // Abort a byte RMW while it is in its write cycle
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd0; bus.sign_ext = 1'b0;
    bus.big_endian = 1'b0; bus.addr = 32'h0C; bus.wdata = 32'h55;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(posedge clk);
    #1 check("abort enwr in WR", 32'(bus.mem_enwr), 32'd1);
    rst_n = 1'b0;
    #1 check("abort enwr", 32'(bus.mem_enwr), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("abort done", 32'(bus.done), 32'd0);
    end
    exp_rdata = '0;
    check("abort mem[3]", mem[3], ref_mem[3]);
    rst_n = 1'b1;
    do_req("after abort", 0, 2'd2, 0, 0, 32'h0C, 32'h0);

    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.size = 2'd2; bus.sign_ext = 1'b0;
    bus.big_endian = 1'b0; bus.addr = 32'h08;
    exp1 = ref_mem[2];
    exp2 = ref_mem[1];
    first = 0;
    second = 0;
    for (int c = 1; c <= 12 && second == 0; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (first == 0) begin
          first = c;
          check("b2b rdata1", bus.rdata, exp1);
          bus.addr = 32'h04;
        end else begin
          second = c;
          check("b2b rdata2", bus.rdata, exp2);
          bus.req = 1'b0;
        end
      end
    end
    bus.req = 1'b0;
    check("b2b gap", second - first, 2);
    exp_rdata = exp2;

    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 127));
      sz = ($urandom_range(0, 11) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'd0;
      end
      do_req($sformatf("rnd%0d", i), 1'($urandom), sz, 1'($urandom), 1'($urandom), a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
